// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - shared bfloat16 types and multiply front-end helper
// Purpose: bfloat16 field layout, exponent constants, the per-operation
//          result record and the combinational sign/exponent/mantissa step.
// Ports:   none (package).
package bf16_pkg;

  localparam int BF16_BIAS = 127;
  localparam int EXP_MAX   = 254;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [15:0] mant;
    logic        zero;
    logic        ovf;
    logic        unf;
  } mul_res_t;

  // Significand with the hidden leading one restored.
  function automatic logic [7:0] bf16_sig(input bf16_t v);
    return {1'b1, v.man};
  endfunction

  // Sign, biased exponent sum, significand product and range flags.
  // The exponent sum is carried in 10 signed bits so that 254+254-bias and
  // 0+0-bias are both representable before the range checks.
  function automatic mul_res_t bf16_mul_front(input bf16_t a, input bf16_t b,
                                              input logic signed [9:0] bias);
    logic signed [9:0] t;
    mul_res_t          r;
    t      = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - bias;
    r      = '0;
    r.sign = a.sign ^ b.sign;
    r.zero = (a.exp == 8'd0) || (b.exp == 8'd0);
    if (!r.zero) begin
      // Exponent 255 (Inf/NaN) is not special-cased; it lands in ovf.
      r.exp  = t[8:0];
      r.mant = {8'h00, bf16_sig(a)} * {8'h00, bf16_sig(b)};
      r.ovf  = t > $signed(10'(EXP_MAX));
      r.unf  = t < 10'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bf16_mul_scheduler_if.sv
// rtl/bf16_mul_scheduler_if.sv - requester and result bundle of the scheduler
// Purpose: groups the per-requester operand handshake and the result stream.
// Ports:   req_valid/req_ready/req_a/req_b (NUM_REQ wide), rsp_valid/rsp_ready,
//          rsp_id/sign/exp/mant/zero/ovf/unf, busy.
//          slave = scheduler side, master = requesters + downstream side.
interface bf16_mul_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][15:0] req_a;
  logic [NUM_REQ-1:0][15:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_sign;
  logic [8:0]               rsp_exp;
  logic [15:0]              rsp_mant;
  logic                     rsp_zero;
  logic                     rsp_ovf;
  logic                     rsp_unf;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sign, rsp_exp, rsp_mant,
           rsp_zero, rsp_ovf, rsp_unf, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sign, rsp_exp, rsp_mant,
           rsp_zero, rsp_ovf, rsp_unf, busy
  );

endinterface

// File: rtl/bf16_mul_scheduler_rr_arbiter.sv
// rtl/bf16_mul_scheduler_rr_arbiter.sv - round-robin pick among requesters
// Purpose: picks the first asserted request at or after ptr_i, wrapping.
// Ports:   req_i     request vector
//          ptr_i     highest-priority index
//          gnt_o     one-hot grant
//          gnt_idx_o index of the grant
//          gnt_any_o some request is granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_any_o
);

  always_comb begin
    int j;
    j         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any_o && req_i[j]) begin
        gnt_any_o = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bf16_mul_scheduler.sv
// rtl/bf16_mul_scheduler.sv - shared two-stage bfloat16 multiply front-end
// Purpose: round-robin arbitrates NUM_REQ operand requesters into a
//          two-stage valid/ready pipeline (S1 = operands, S2 = results).
// Ports:   clk  clock
//          rst  synchronous active-high reset
//          bus  slave side of bf16_mul_scheduler_if (requests, results, busy)
module bf16_mul_scheduler
  import bf16_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int BIAS    = BF16_BIAS
) (
  input  logic                        clk,
  input  logic                        rst,
  bf16_mul_scheduler_if.slave         bus
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               s1_valid_q;
  logic [ID_W-1:0]    s1_id_q;
  bf16_t              s1_a_q, s1_b_q;
  logic               s2_valid_q;
  logic [ID_W-1:0]    s2_id_q;
  mul_res_t           s2_res_q;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               s2_free, s1_free, accept;
  mul_res_t           s1_res;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // A stage can take new contents if it is empty or is handing off this
  // cycle, so a full pipeline with a ready consumer never bubbles.
  assign s2_free = !s2_valid_q || bus.rsp_ready;
  assign s1_free = !s1_valid_q || s2_free;
  assign accept  = gnt_any && s1_free && !rst;

  assign bus.req_ready = accept ? gnt : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign s1_res = bf16_mul_front(s1_a_q, s1_b_q, 10'(BIAS));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_res_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (s2_free) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_id_q  <= s1_id_q;
          s2_res_q <= s1_res;
        end
      end
      if (s1_free) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_id_q <= gnt_idx;
          s1_a_q  <= bf16_t'(bus.req_a[gnt_idx]);
          s1_b_q  <= bf16_t'(bus.req_b[gnt_idx]);
        end
      end
    end
  end

  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_id    = s2_id_q;
  assign bus.rsp_sign  = s2_res_q.sign;
  assign bus.rsp_exp   = s2_res_q.exp;
  assign bus.rsp_mant  = s2_res_q.mant;
  assign bus.rsp_zero  = s2_res_q.zero;
  assign bus.rsp_ovf   = s2_res_q.ovf;
  assign bus.rsp_unf   = s2_res_q.unf;
  assign bus.busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_bf16_mul_scheduler.sv
// tb/tb_bf16_mul_scheduler.sv - scoreboard bench for bf16_mul_scheduler
module tb_bf16_mul_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf16_mul_scheduler_if #(.NUM_REQ(N)) bus_if ();

  bf16_mul_scheduler #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    int id;
    int sign;
    int exp;
    int mant;
    int zero;
    int ovf;
    int unf;
    int stamp;
    bit strict;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          mptr  = 0;
  int          cyc   = 0;
  bit          just_reset = 0;
  bit          have_hold  = 0;
  bit          free_flow  = 0;
  logic [N-1:0] hs_vec = '0;
  logic [31:0] held;
  logic [31:0] snap;

  bit          pend_v[N];
  logic [15:0] pend_a[N];
  logic [15:0] pend_b[N];
  bit          dir_v[N];
  exp_t        dir_e[N];

  assign snap = {1'b0, bus_if.rsp_id, bus_if.rsp_sign, bus_if.rsp_exp, bus_if.rsp_mant,
                 bus_if.rsp_zero, bus_if.rsp_ovf, bus_if.rsp_unf};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: arithmetic straight from the bfloat16 field definitions.
  function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ea, eb, ma, mb, t;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    ma = int'(a[6:0]);
    mb = int'(b[6:0]);
    t  = ea + eb - 127;
    e.id   = id;
    e.sign = int'(a[15] ^ b[15]);
    e.zero = (ea == 0 || eb == 0) ? 1 : 0;
    e.exp  = e.zero ? 0 : (t & 511);
    e.mant = e.zero ? 0 : (128 + ma) * (128 + mb);
    e.ovf  = (!e.zero && t > 254) ? 1 : 0;
    e.unf  = (!e.zero && t < 1) ? 1 : 0;
    e.stamp  = 0;
    e.strict = 0;
    return e;
  endfunction

  // Monitor: checks arbitration, occupancy, result stream; records handshakes.
  always @(negedge clk) begin : mon
    int   g;
    int   idx;
    logic [N-1:0] expv;
    exp_t e;
    if (rst) begin
      chk("ready_in_reset", 32'(bus_if.req_ready), 32'd0);
      sb.delete();
      mptr       = 0;
      just_reset = 1;
      have_hold  = 0;
      hs_vec     = '0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && bus_if.req_valid[idx]) g = idx;
      end
      expv = '0;
      if (g >= 0 && (sb.size() < 2 || bus_if.rsp_ready)) expv[g] = 1'b1;
      chk("req_ready", 32'(bus_if.req_ready), 32'(expv));
      chk("busy", 32'(bus_if.busy), 32'(sb.size() != 0));
      if (just_reset) begin
        chk("post_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("post_rst_rsp_exp", 32'(bus_if.rsp_exp), 32'd0);
        chk("post_rst_rsp_mant", 32'(bus_if.rsp_mant), 32'd0);
        just_reset = 0;
      end
      if (have_hold) begin
        chk("hold_valid", 32'(bus_if.rsp_valid), 32'd1);
        chk("hold_data", snap, held);
      end
      have_hold = bus_if.rsp_valid && !bus_if.rsp_ready;
      held      = snap;
      if (bus_if.rsp_valid && bus_if.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(bus_if.rsp_id), 32'(e.id));
          chk("rsp_sign", 32'(bus_if.rsp_sign), 32'(e.sign));
          chk("rsp_exp", 32'(bus_if.rsp_exp), 32'(e.exp));
          chk("rsp_mant", 32'(bus_if.rsp_mant), 32'(e.mant));
          chk("rsp_zero", 32'(bus_if.rsp_zero), 32'(e.zero));
          chk("rsp_ovf", 32'(bus_if.rsp_ovf), 32'(e.ovf));
          chk("rsp_unf", 32'(bus_if.rsp_unf), 32'(e.unf));
          if (e.strict) chk("latency", 32'(cyc - e.stamp), 32'd2);
        end
      end
      hs_vec = bus_if.req_valid & bus_if.req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs_vec[i]) begin
          if (dir_v[i]) begin
            e        = dir_e[i];
            dir_v[i] = 0;
          end else begin
            e = model(i, bus_if.req_a[i], bus_if.req_b[i]);
          end
          e.stamp  = cyc;
          e.strict = free_flow;
          sb.push_back(e);
          mptr = (i + 1) % N;
        end
      end
      cyc++;
    end
  end

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus_if.req_valid[i] = pend_v[i];
      bus_if.req_a[i]     = pend_a[i];
      bus_if.req_b[i]     = pend_b[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs_vec[i]) pend_v[i] = 0;
  endtask

  function automatic logic [15:0] rnd_bf16();
    logic [15:0] v;
    int          pick;
    v = 16'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0: v[14:7] = 8'd0;
        1: v[14:7] = 8'd1;
        2: v[14:7] = 8'd254;
        default: v[14:7] = 8'd255;
      endcase
    end
    return v;
  endfunction

  task automatic refill_all();
    for (int i = 0; i < N; i++) begin
      if (!pend_v[i]) begin
        pend_v[i] = 1;
        pend_a[i] = rnd_bf16();
        pend_b[i] = rnd_bf16();
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    bus_if.rsp_ready = 1'b1;
    apply();
    n = 0;
    while ((sb.size() != 0 || bus_if.busy) && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic send_dir(input int id, input logic [15:0] a, input logic [15:0] b,
                          input int sg, input int ex, input int mn,
                          input int z, input int o, input int u);
    int n;
    dir_e[id].id   = id;
    dir_e[id].sign = sg;
    dir_e[id].exp  = ex;
    dir_e[id].mant = mn;
    dir_e[id].zero = z;
    dir_e[id].ovf  = o;
    dir_e[id].unf  = u;
    dir_v[id]      = 1;
    pend_v[id]     = 1;
    pend_a[id]     = a;
    pend_b[id]     = b;
    bus_if.rsp_ready = 1'b1;
    apply();
    n = 0;
    while (pend_v[id] && n < 20) begin
      tick();
      apply();
      n++;
    end
    chk("dir_accepted", 32'(pend_v[id]), 32'd0);
    drain(20);
  endtask

  initial begin : stim
    int cnt;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 0;
      pend_a[i] = '0;
      pend_b[i] = '0;
      dir_v[i]  = 0;
    end
    bus_if.rsp_ready = 1'b1;
    apply();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    free_flow = 1;
    send_dir(2, 16'h3F80, 16'h4000, 0, 128, 16'h4000, 0, 0, 0);
    send_dir(1, 16'h7F00, 16'h7F00, 0, 381, 16'h4000, 0, 1, 0);
    send_dir(3, 16'h0080, 16'h0080, 0, 387, 16'h4000, 0, 0, 1);
    send_dir(0, 16'h0000, 16'h3F80, 0, 0, 0, 1, 0, 0);
    send_dir(2, 16'hBF80, 16'h3F80, 1, 127, 16'h4000, 0, 0, 0);

    // Fairness: all requesters busy, downstream always ready.
    for (int c = 0; c < 24; c++) begin
      refill_all();
      apply();
      tick();
    end
    drain(20);
    free_flow = 0;

    // Backpressure: five stalled cycles admit exactly two operations.
    bus_if.rsp_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      refill_all();
      apply();
      tick();
      cnt += $countones(hs_vec);
    end
    chk("bp_accepts", 32'(cnt), 32'd2);
    drain(20);

    // Randomized traffic with random downstream stalls.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) != 0) begin
          pend_v[i] = 1;
          pend_a[i] = rnd_bf16();
          pend_b[i] = rnd_bf16();
        end
      end
      bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
      apply();
      tick();
    end
    drain(20);

    // Reset with both stages occupied.
    bus_if.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      refill_all();
      apply();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = (i == 1 || i == 3);
      pend_a[i] = rnd_bf16();
      pend_b[i] = rnd_bf16();
    end
    bus_if.rsp_ready = 1'b1;
    apply();
    tick();
    chk("post_rst_first_grant", 32'(hs_vec), 32'b0010);
    apply();
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf16_mul_scheduler.md
# bf16_mul_scheduler

Round-robin scheduler that shares one two-stage bfloat16 multiply front-end among NUM_REQ requesters. It arbitrates operand requests, issues at most one operation per cycle into a valid/ready pipeline, and returns per-operation sign, biased exponent sum, mantissa product and range flags, tagged with the requester ID. It sits between the PE operand queues and the shared normalize/round stage.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of the requester tag
- BIAS, 127, bfloat16 exponent bias
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_a  in  NUM_REQ x 16  bfloat16 operand A per requester
- req_b  in  NUM_REQ x 16  bfloat16 operand B per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accept
- rsp_id  out  ID_W  requester that issued the result
- rsp_sign  out  1  sign_a XOR sign_b
- rsp_exp  out  9  exp_a + exp_b - BIAS, low 9 bits
- rsp_mant  out  16  {1,man_a} x {1,man_b}
- rsp_zero  out  1  either operand exponent field is 0
- rsp_ovf  out  1  true exponent sum > 254
- rsp_unf  out  1  true exponent sum < 1, operands nonzero
- busy  out  1  any pipeline stage holds a valid operation

## Operation
- Arbiter: round-robin over req_valid starting at pointer ptr; highest priority is ptr, then ptr+1 … wrapping modulo NUM_REQ.
- req_ready[g] = 1 only for the chosen index g and only when stage 1 can accept (s1 empty or s1 advancing this cycle).
- ptr updates to (g+1) mod NUM_REQ only on an accepted handshake (req_valid[g] & req_ready[g]); otherwise unchanged.
- Stage 1 (S1): registers id, a, b.
- Stage 2 (S2): registers computed results from S1 contents:
  - exponent: 10-bit signed sum t = exp_a + exp_b - BIAS; rsp_exp = t[8:0].
  - zero: exp_a==0 or exp_b==0 → rsp_zero=1, rsp_exp=0, rsp_mant=0, ovf=unf=0 (subnormals flushed).
  - ovf = !zero & (t > 254); unf = !zero & (t < 1). Exponent field 255 (Inf/NaN) is treated arithmetically; ovf covers it.
  - mantissa: 8x8 unsigned product of hidden-bit-extended mantissas.
- Pipeline advance: S2 loads when S2 empty or rsp_valid & rsp_ready; S1 loads when S1 empty or S1 moves to S2. No bubbles inserted when downstream is ready.
- rsp_* equal S2 registers; rsp_valid = S2 valid. Outputs hold stable while rsp_valid & !rsp_ready.

## Timing
- Latency: handshake at cycle N → rsp_valid at cycle N+2 when rsp_ready held high.
- Throughput: one operation per cycle sustained.
- Backpressure: with rsp_ready low, S2 then S1 fill; req_ready all 0 thereafter; maximum 2 operations in flight.
- Reset: ptr=0, S1/S2 valid=0, rsp_valid=0, req_ready=0 during reset cycle, busy=0, rsp data fields=0. Reset mid-operation discards in-flight operations; no result emitted for them.
- req_ready is combinational from req_valid, ptr, and pipeline state; requesters must not make req_valid depend on req_ready.
- Simultaneous: S2 drain and S1 load and new request acceptance all occur in one cycle.

## Structure
- Shared package bf16_pkg: BF16_BIAS=127, EXP_MAX=254, typedef bf16_t packed struct {sign, exp[7:0], man[6:0]}, field extraction helpers.
- Sub-module rr_arbiter (NUM_REQ request vector, ptr, grant one-hot, grant index); scheduler holds ptr and pipeline.

## Test plan
- Single op: requester 2 sends a=0x3F80 (1.0), b=0x4000 (2.0) → two cycles later rsp_id=2, sign=0, exp=128, mant=0x4000, flags 0.
- Fairness: all 4 valid continuously from reset, rsp_ready=1 → grants 0,1,2,3,0,1… one per cycle; rsp_id follows.
- Backpressure: rsp_ready=0 for 5 cycles with all requesting → exactly 2 accepts, then req_ready=0; on release results drain in order, no loss or duplication.
- Range: a=0x7F00,b=0x7F00 (exp 254+254-127=381) → ovf=1; a=0x0080,b=0x0080 (1+1-127=-125) → unf=1; a=0x0000 → zero=1, exp=0.
- Sign: a=0xBF80, b=0x3F80 → sign=1, exp=127, mant=0x4000.
- Reset mid-flight: assert rst with S1 and S2 full → next cycle rsp_valid=0, busy=0, ptr=0, first post-reset grant goes to lowest valid index.
